// File: rtl/spectrum_pkg.sv
// Shared constants and FSM encoding for the spectrum frame writer.
package spectrum_pkg;

  localparam int NPTS  = 512;
  localparam int IDX_W = 9;
  localparam int HGT_W = 9;
  localparam int HMAX  = 479;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WAIT_SWAP
  } state_t;

endpackage

// File: rtl/spectrum_frame_writer_ram.sv
// Simple dual-port bank RAM: one write port, one synchronous read port.
module spec_bank_ram
  import spectrum_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [HGT_W-1:0] wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [HGT_W-1:0] rdata
);

  logic [HGT_W-1:0] mem [NPTS];

  // Write when enabled; the read data is registered (one-cycle latency).
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/spectrum_frame_writer.sv
// Spectrum frame writer: squares FFT bins into bar heights, fills a
// ping-pong bank pair and swaps banks on frame_sync once a frame is complete.
// Optional feature macro: SPECTRUM_PEAK_HOLD_EN (decaying peak hold).
module spectrum_frame_writer
  import spectrum_pkg::*;
#(
  parameter int DW         = 8,
  parameter int SHIFT      = 6,
  parameter int PEAK_DECAY = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 xk_dv,
  input  logic [IDX_W-1:0]     xk_index,
  input  logic signed [DW-1:0] xk_re,
  input  logic signed [DW-1:0] xk_im,
  input  logic                 frame_sync,
  input  logic [IDX_W-1:0]     rd_addr,
  output logic [HGT_W-1:0]     rd_data,
  output logic                 frame_ready,
  output logic                 bank_sel,
  output logic                 seq_err,
  output logic                 overrun
);

  function automatic logic [HGT_W-1:0] sat_height(input logic [2*DW-1:0] pwr);
    logic [2*DW-1:0] scaled;
    scaled = pwr >> SHIFT;
    if (scaled > (2*DW)'(HMAX)) return HGT_W'(HMAX);
    return scaled[HGT_W-1:0];
  endfunction

  function automatic logic [HGT_W-1:0] peak_hold(input logic [HGT_W-1:0] h,
                                                 input logic [HGT_W-1:0] pk);
    logic [HGT_W-1:0] dec;
    dec = (pk > HGT_W'(PEAK_DECAY)) ? pk - HGT_W'(PEAK_DECAY) : '0;
    return (h > dec) ? h : dec;
  endfunction

  logic                 vld_p1, vld_p2;
  logic [IDX_W-1:0]     idx_p1, idx_p2;
  logic signed [DW-1:0] re_p1, im_p1;
  logic signed [2*DW-1:0] sq_re, sq_im;
  logic [2*DW-1:0]      pwr_p2;
  logic [HGT_W-1:0]     hgt, wr_hgt;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] exp_idx, exp_nxt;
  logic             wr_en, swap, seq_set;
  logic             disp_valid, rd_valid, rd_sel;
  logic [HGT_W-1:0] rdata0, rdata1;

  // ---- S1: input register ----
  // Valid travels with the sample; only the valid bit is reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= xk_dv;
      vld_p2 <= vld_p1;
    end
  end

  // Sample data pipeline (no reset needed on data).
  always_ff @(posedge clk) begin
    idx_p1 <= xk_index;
    re_p1  <= xk_re;
    im_p1  <= xk_im;
    idx_p2 <= idx_p1;
    pwr_p2 <= $unsigned(sq_re) + $unsigned(sq_im);
  end

  // ---- S2: power = re^2 + im^2 (squares are non-negative, sum fits 2*DW bits) ----
  assign sq_re = re_p1 * re_p1;
  assign sq_im = im_p1 * im_p1;

  // ---- S3: scale, saturate, optional peak hold, bank write ----
  assign hgt = sat_height(pwr_p2);

`ifdef SPECTRUM_PEAK_HOLD_EN
  logic [HGT_W-1:0] peak_rd, peak_p2;

  // Peak RAM is read at S1 by the incoming index; its data is aligned to S3.
  always_ff @(posedge clk) begin
    peak_p2 <= peak_rd;
  end

  // Until the first swap the peak RAM holds garbage, so treat it as zero.
  assign wr_hgt = disp_valid ? peak_hold(hgt, peak_p2) : hgt;

  spec_bank_ram u_peak (
    .clk  (clk),
    .we   (wr_en),
    .waddr(idx_p2),
    .wdata(wr_hgt),
    .raddr(xk_index),
    .rdata(peak_rd)
  );
`else
  assign wr_hgt = hgt;
`endif

  // Frame sequencing judged on the S3 sample, so the state follows the writes.
  always_comb begin
    state_nxt = state;
    exp_nxt   = exp_idx;
    wr_en     = 1'b0;
    swap      = 1'b0;
    seq_set   = 1'b0;
    unique case (state)
      IDLE: begin
        if (vld_p2 && idx_p2 == '0) begin
          wr_en     = 1'b1;
          exp_nxt   = IDX_W'(1);
          state_nxt = FILL;
        end
      end
      FILL: begin
        if (vld_p2) begin
          if (idx_p2 == exp_idx) begin
            wr_en = 1'b1;
            if (exp_idx == IDX_W'(NPTS-1)) state_nxt = WAIT_SWAP;
            else                           exp_nxt   = exp_idx + IDX_W'(1);
          end else begin
            // Discontinuity: abandon, but the same sample may restart a frame.
            seq_set = 1'b1;
            if (idx_p2 == '0) begin
              wr_en   = 1'b1;
              exp_nxt = IDX_W'(1);
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      WAIT_SWAP: begin
        if (frame_sync) begin
          swap      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, bank control and sticky status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      exp_idx     <= '0;
      bank_sel    <= 1'b0;
      frame_ready <= 1'b0;
      disp_valid  <= 1'b0;
      seq_err     <= 1'b0;
      overrun     <= 1'b0;
      rd_valid    <= 1'b0;
      rd_sel      <= 1'b0;
    end else begin
      state       <= state_nxt;
      exp_idx     <= exp_nxt;
      bank_sel    <= bank_sel ^ swap;
      frame_ready <= swap;
      disp_valid  <= disp_valid | swap;
      seq_err     <= seq_err | seq_set;
      overrun     <= overrun | (xk_dv && state == WAIT_SWAP);
      rd_valid    <= disp_valid;
      rd_sel      <= ~bank_sel;
    end
  end

  spec_bank_ram u_bank0 (
    .clk  (clk),
    .we   (wr_en && !bank_sel),
    .waddr(idx_p2),
    .wdata(wr_hgt),
    .raddr(rd_addr),
    .rdata(rdata0)
  );

  spec_bank_ram u_bank1 (
    .clk  (clk),
    .we   (wr_en && bank_sel),
    .waddr(idx_p2),
    .wdata(wr_hgt),
    .raddr(rd_addr),
    .rdata(rdata1)
  );

  // Read mux uses the bank/valid captured at the same edge as the RAM read.
  assign rd_data = rd_valid ? (rd_sel ? rdata1 : rdata0) : '0;

endmodule

// File: tb/tb_spectrum_frame_writer.sv
// Self-checking bench for spectrum_frame_writer (default build and
// SPECTRUM_PEAK_HOLD_EN build).
module tb_spectrum_frame_writer;
  import spectrum_pkg::*;

  localparam int DW = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 xk_dv = 1'b0;
  logic [IDX_W-1:0]     xk_index = '0;
  logic signed [DW-1:0] xk_re = '0;
  logic signed [DW-1:0] xk_im = '0;
  logic                 frame_sync = 1'b0;
  logic [IDX_W-1:0]     rd_addr = '0;
  logic [HGT_W-1:0]     rd_data;
  logic                 frame_ready, bank_sel, seq_err, overrun;

  int vectors = 0;
  int miscompares = 0;
  int ready_pulses = 0;
  int fre [NPTS];
  int fim [NPTS];

  spectrum_frame_writer dut (
    .clk(clk), .rst_n(rst_n), .xk_dv(xk_dv), .xk_index(xk_index),
    .xk_re(xk_re), .xk_im(xk_im), .frame_sync(frame_sync),
    .rd_addr(rd_addr), .rd_data(rd_data), .frame_ready(frame_ready),
    .bank_sel(bank_sel), .seq_err(seq_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int height(input int r, input int i);
    int p;
    p = (r * r + i * i) >> 6;
    return (p > 479) ? 479 : p;
  endfunction

  // ---------------- behavioural model ----------------
  // mode: 0 = no frame, 1 = collecting, 2 = complete and awaiting sync
  int m_mode, m_next, m_rd;
  int m_pend [NPTS];
  int m_disp [NPTS];
  int m_peak [NPTS];
  bit m_dvalid, m_bank, m_ready, m_seq, m_ovr;
  bit p_v [2];
  int p_i [2];
  int p_h [2];
  bit cv;
  int ci, ch, w, mode0, dec;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_next = 0; m_rd = 0;
      m_dvalid = 0; m_bank = 0; m_ready = 0; m_seq = 0; m_ovr = 0;
      p_v[0] = 0; p_v[1] = 0;
    end else begin
      mode0 = m_mode;
      cv = p_v[1]; ci = p_i[1]; ch = p_h[1];
      p_v[1] = p_v[0]; p_i[1] = p_i[0]; p_h[1] = p_h[0];
      p_v[0] = xk_dv; p_i[0] = int'(xk_index); p_h[0] = height(int'(xk_re), int'(xk_im));
      m_rd = m_dvalid ? m_disp[rd_addr] : 0;
      m_ready = 0;
      if (mode0 == 2) begin
        if (xk_dv) m_ovr = 1;
        if (frame_sync) begin
          m_disp = m_pend;
          m_bank = !m_bank;
          m_ready = 1;
          m_dvalid = 1;
          m_mode = 0;
        end
      end else if (cv) begin
        if (m_mode == 1 && ci != m_next) begin
          m_seq = 1;
          m_mode = 0;
        end
        if ((m_mode == 1 && ci == m_next) || (m_mode == 0 && ci == 0)) begin
          w = ch;
`ifdef SPECTRUM_PEAK_HOLD_EN
          if (m_dvalid) begin
            dec = m_peak[ci] - 4;
            if (dec < 0) dec = 0;
            if (dec > w) w = dec;
          end
          m_peak[ci] = w;
`endif
          m_pend[ci] = w;
          if (ci == NPTS - 1) m_mode = 2;
          else begin
            m_mode = 1;
            m_next = ci + 1;
          end
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(posedge clk) begin
    #1;
    check("bank_sel", int'(bank_sel), int'(m_bank));
    check("frame_ready", int'(frame_ready), int'(m_ready));
    check("seq_err", int'(seq_err), int'(m_seq));
    check("overrun", int'(overrun), int'(m_ovr));
    check("rd_data", int'(rd_data), m_rd);
    if (frame_ready) ready_pulses++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic fill(input int r, input int i);
    for (int k = 0; k < NPTS; k++) begin
      fre[k] = r;
      fim[k] = i;
    end
  endtask

  task automatic send_range(input int first, input int last);
    for (int k = first; k <= last; k++) begin
      @(negedge clk);
      xk_dv = 1'b1;
      xk_index = IDX_W'(k);
      xk_re = DW'(fre[k]);
      xk_im = DW'(fim[k]);
    end
    @(negedge clk);
    xk_dv = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sync_pulse();
    @(negedge clk);
    frame_sync = 1'b1;
    @(negedge clk);
    frame_sync = 1'b0;
    idle(2);
  endtask

  task automatic read_bin(input int a, output int v);
    @(negedge clk);
    rd_addr = IDX_W'(a);
    @(posedge clk);
    #2;
    v = int'(rd_data);
  endtask

  int v, pulses0;

  initial begin
    // Reset state
    idle(3);
    #1;
    check("reset rd_data", int'(rd_data), 0);
    check("reset bank_sel", int'(bank_sel), 0);
    check("reset flags", int'({frame_ready, seq_err, overrun}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Uniform frame 40/30 -> 2500>>6 = 39
    fill(40, 30);
    send_range(0, NPTS - 1);
    idle(5);
    read_bin(0, v);
    check("pre-swap rd_data", v, 0);
    pulses0 = ready_pulses;
    sync_pulse();
    check("t1 ready pulses", ready_pulses - pulses0, 1);
    check("t1 bank_sel", int'(bank_sel), 1);
    read_bin(0, v);   check("t1 bin0", v, 39);
    read_bin(255, v); check("t1 bin255", v, 39);
    read_bin(511, v); check("t1 bin511", v, 39);

    // Saturated bin 7
    fill(0, 0);
    fre[7] = -128; fim[7] = -128;
    send_range(0, NPTS - 1);
    idle(5);
    sync_pulse();
    check("t2 bank_sel", int'(bank_sel), 0);
    read_bin(7, v); check("t2 bin7", v, 479);
`ifndef SPECTRUM_PEAK_HOLD_EN
    read_bin(6, v); check("t2 bin6", v, 0);
`endif

    // Index discontinuity 0..99 then 101
    fill(10, 0);
    pulses0 = ready_pulses;
    send_range(0, 99);
    send_range(101, 101);
    idle(5);
    check("t3 seq_err", int'(seq_err), 1);
    sync_pulse();
    check("t3 no swap", int'(bank_sel), 0);
    check("t3 no pulse", ready_pulses - pulses0, 0);
    read_bin(7, v); check("t3 bin7 kept", v, 479);

    // Overrun: 3 samples after completion, before sync. 20/20 -> 800>>6 = 12
    fill(20, 20);
    send_range(0, NPTS - 1);
    idle(5);
    fill(127, 127);
    send_range(0, 2);
    idle(5);
    check("t4 overrun", int'(overrun), 1);
    sync_pulse();
    check("t4 bank_sel", int'(bank_sel), 1);
`ifndef SPECTRUM_PEAK_HOLD_EN
    read_bin(0, v); check("t4 bin0", v, 12);
    read_bin(2, v); check("t4 bin2", v, 12);
`endif

    // Last write coincident with frame_sync: 30/0 -> 900>>6 = 14
    fill(30, 0);
    pulses0 = ready_pulses;
    send_range(0, NPTS - 1);
    @(negedge clk);
    frame_sync = 1'b1;
    @(negedge clk);
    frame_sync = 1'b0;
    idle(3);
    check("t5 no swap", int'(bank_sel), 1);
    check("t5 no pulse", ready_pulses - pulses0, 0);
    sync_pulse();
    check("t5 swap", int'(bank_sel), 0);
`ifndef SPECTRUM_PEAK_HOLD_EN
    read_bin(100, v); check("t5 bin100", v, 14);
`endif

    // Reset mid-frame
    fill(50, 50);
    send_range(0, 199);
    rst_n = 1'b0;
    idle(2);
    #1;
    check("t7 reset bank_sel", int'(bank_sel), 0);
    check("t7 reset flags", int'({frame_ready, seq_err, overrun}), 0);
    check("t7 reset rd_data", int'(rd_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    read_bin(0, v); check("t7 rd_data post-reset", v, 0);
    fill(8, 8);
    send_range(0, NPTS - 1);
    idle(5);
    read_bin(3, v); check("t7 before swap", v, 0);
    sync_pulse();
    check("t7 bank_sel", int'(bank_sel), 1);
    read_bin(3, v); check("t7 bin3", v, 2);

`ifdef SPECTRUM_PEAK_HOLD_EN
    // Peak hold: bin 3 = 100 (80^2>>6), then zero frames decay by 4
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    fill(0, 0);
    fre[3] = 80;
    send_range(0, NPTS - 1);
    idle(5);
    sync_pulse();
    read_bin(3, v); check("peak f1", v, 100);
    fill(0, 0);
    send_range(0, NPTS - 1);
    idle(5);
    sync_pulse();
    read_bin(3, v); check("peak f2", v, 96);
    send_range(0, NPTS - 1);
    idle(5);
    sync_pulse();
    read_bin(3, v); check("peak f3", v, 92);
`endif

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
